// File: rtl/bus_pkg.sv
// Shared serial-bus definitions for the master and slave bus bridges.
// Frame layout on wr_bus: {addr, wdata} MSB first; mode travels out-of-band.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 8;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_ADDR_OUT = 3'd2,
    ST_DATA_OUT = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_IN    = 3'd5,
    ST_DONE     = 3'd6
  } mbb_state_e;

  // Serial frame payload: address followed by data.
  function automatic int frame_width(input int aw, input int dw);
    return aw + dw;
  endfunction

  // Parallel request word: {mode, addr, data}.
  function automatic int req_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Left-shifting register with parallel load; exposes its OUT_W most significant bits.
// load has priority over shift; shift_i doubles as the enable.
module bus_shift_reg #(
  parameter int W     = 8,
  parameter int OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [W-1:0]     load_dat_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [OUT_W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_dat_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q[W-1 -: OUT_W];

endmodule

// File: rtl/master_bus_bridge.sv
// Master end of the serial bus: serialises {addr,wdata}, deserialises read replies.
// Write latency 1+1+ADDR_WIDTH+DATA_WIDTH+1 cycles at zero stall; slave_ready/slave_valid stall bit by bit.
module master_bus_bridge
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] uart_register_in,
  output logic                          ready_out,
  output logic [DATA_WIDTH-1:0]         uart_register_out,
  output logic                          valid_out,
  output logic                          error,
  output logic                          mode,
  output logic                          wr_bus,
  output logic                          master_valid,
  output logic                          master_ready,
  input  logic                          rd_bus,
  input  logic                          slave_ready,
  input  logic                          slave_valid,
  input  logic                          split
);

  localparam int FW = frame_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  mbb_state_e            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rd_out_q, rd_out_d;

  logic                  tx_load;
  logic                  tx_shift;
  logic                  tx_msb;
  logic                  rx_shift;
  logic [DATA_WIDTH-2:0] rx_q;

  bus_shift_reg #(
    .W     (FW),
    .OUT_W (1)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .load_dat_i (uart_register_in[FW-1:0]),
    .shift_i    (tx_shift),
    .ser_i      (1'b0),
    .q_o        (tx_msb)
  );

  // Holds the first DATA_WIDTH-1 read bits; the last bit goes straight to the output register.
  bus_shift_reg #(
    .W     (DATA_WIDTH - 1),
    .OUT_W (DATA_WIDTH - 1)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (1'b0),
    .load_dat_i ('0),
    .shift_i    (rx_shift),
    .ser_i      (rd_bus),
    .q_o        (rx_q)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    mode_d       = mode_q;
    rd_out_d     = rd_out_q;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    rx_shift     = 1'b0;
    ready_out    = 1'b0;
    valid_out    = 1'b0;
    error        = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          mode_d    = uart_register_in[FW];
          tx_load   = 1'b1;
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        master_valid = 1'b1;
        if (slave_ready) begin
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = ST_ADDR_OUT;
        end else if (tmo_cnt_q == TMO_MAX) begin
          error     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_ADDR_OUT: begin
        master_valid = 1'b1;
        if (slave_ready) begin
          tx_shift = 1'b1;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
            state_d   = (mode_q == MODE_WRITE) ? ST_DATA_OUT : ST_RD_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_DATA_OUT: begin
        master_valid = 1'b1;
        if (slave_ready) begin
          tx_shift = 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      // A split parks here indefinitely; only unsplit idle cycles count toward the timeout.
      ST_RD_WAIT: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          rx_shift  = 1'b1;
          bit_cnt_d = CW'(1);
          state_d   = ST_RD_IN;
        end else if (!split) begin
          if (tmo_cnt_q == TMO_MAX) begin
            error     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end

      ST_RD_IN: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          if (bit_cnt_q == DATA_LAST) begin
            rd_out_d  = {rx_q, rd_bus};
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            rx_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        valid_out = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      mode_q    <= 1'b0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      mode_q    <= mode_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // The TX register keeps stale contents in IDLE; gating keeps the line quiet between frames.
  assign wr_bus            = master_valid & tx_msb;
  assign mode              = mode_q;
  assign uart_register_out = rd_out_q;

endmodule

// File: tb/tb_master_bus_bridge.sv
// Directed bench for master_bus_bridge: write, split read, stalls, timeout, reset, back-to-back.
module tb_master_bus_bridge;

  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [AW+DW:0] uart_register_in = '0;
  logic          ready_out;
  logic [DW-1:0] uart_register_out;
  logic          valid_out;
  logic          error;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          master_ready;
  logic          rd_bus = 1'b0;
  logic          slave_ready = 1'b0;
  logic          slave_valid = 1'b0;
  logic          split = 1'b0;

  int errors = 0;
  int checks = 0;

  master_bus_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .uart_register_in  (uart_register_in),
    .ready_out         (ready_out),
    .uart_register_out (uart_register_out),
    .valid_out         (valid_out),
    .error             (error),
    .mode              (mode),
    .wr_bus            (wr_bus),
    .master_valid      (master_valid),
    .master_ready      (master_ready),
    .rd_bus            (rd_bus),
    .slave_ready       (slave_ready),
    .slave_valid       (slave_valid),
    .split             (split)
  );

  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave-side observer for one write frame; cycle 0 is the acceptance cycle.
  task automatic run_frame(input logic [AW+DW:0] req, input bit stall,
                           output logic [AW+DW-1:0] bits, output int nbits,
                           output int lat, output int nerr, output int nhold_bad,
                           output logic mode_seen);
    bit   in_req;
    bit   prev_stall;
    logic prev_bit;
    bits = '0; nbits = 0; lat = -1; nerr = 0; nhold_bad = 0; mode_seen = 1'bx;
    in_req = 1'b1; prev_stall = 1'b0; prev_bit = 1'b0;
    step();
    valid_in = 1'b1;
    uart_register_in = req;
    slave_ready = stall ? 1'b0 : 1'b1;
    for (int c = 1; c < 120; c++) begin
      step();
      valid_in = 1'b0;
      slave_ready = stall ? ((c % 2) == 1) : 1'b1;
      #1;
      if (c == 1) mode_seen = mode;
      if (error) nerr++;
      if (master_valid) begin
        if (prev_stall && wr_bus !== prev_bit) nhold_bad++;
        if (in_req) begin
          if (slave_ready) in_req = 1'b0;
          prev_stall = 1'b0;
        end else if (slave_ready) begin
          bits = {bits[AW+DW-2:0], wr_bus};
          nbits++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_bit = wr_bus;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (valid_out) begin
        lat = c;
        break;
      end
    end
    slave_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst = 1'b1;
    step();
    step();
    #1;
    obs = {ready_out, master_valid, master_ready, wr_bus, mode, valid_out, error, uart_register_out};
    checks++;
    if (obs !== {1'b1, 6'd0, 8'd0})
      $display("FAIL reset_outputs: got %b expected %b", obs, {1'b1, 6'd0, 8'd0});
    if (obs !== {1'b1, 6'd0, 8'd0}) errors++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_nostall();
    logic [AW+DW-1:0] bits;
    int nbits, lat, nerr, nhold;
    logic m;
    run_frame({1'b1, 16'hA5C3, 8'h3C}, 1'b0, bits, nbits, lat, nerr, nhold, m);
    checks++;
    if (bits !== 24'hA5C33C) begin errors++; $display("FAIL write_bits: got %h expected a5c33c", bits); end
    checks++;
    if (nbits !== 24) begin errors++; $display("FAIL write_nbits: got %0d expected 24", nbits); end
    checks++;
    if (lat !== 26) begin errors++; $display("FAIL write_latency: valid_out at cycle %0d expected 26 (27 cycles inclusive)", lat); end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL write_error: error seen %0d times expected 0", nerr); end
    checks++;
    if (m !== 1'b1) begin errors++; $display("FAIL write_mode: got %b expected 1", m); end
  endtask

  task automatic test_stall();
    logic [AW+DW-1:0] bits;
    int nbits, lat, nerr, nhold;
    logic m;
    run_frame({1'b1, 16'h0001, 8'hFF}, 1'b1, bits, nbits, lat, nerr, nhold, m);
    checks++;
    if (bits !== 24'h0001FF) begin errors++; $display("FAIL stall_bits: got %h expected 0001ff", bits); end
    checks++;
    if (nbits !== 24) begin errors++; $display("FAIL stall_nbits: got %0d expected 24", nbits); end
    checks++;
    if (nhold !== 0) begin errors++; $display("FAIL stall_hold: wr_bus changed during %0d stalls expected 0", nhold); end
    checks++;
    if (lat !== 50) begin errors++; $display("FAIL stall_latency: valid_out at cycle %0d expected 50", lat); end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL stall_error: error seen %0d times expected 0", nerr); end
  endtask

  task automatic test_read_split();
    logic [AW-1:0] abits;
    logic [DW-1:0] rpat;
    int na, nerr, cw;
    bit mr_drop, got;
    logic [DW-1:0] rdat;
    abits = '0; rpat = 8'hE7; na = 0; nerr = 0; cw = -1; mr_drop = 0; got = 0; rdat = 'x;
    step();
    valid_in = 1'b1;
    uart_register_in = {1'b0, 16'h1234, 8'h00};
    slave_ready = 1'b1;
    for (int c = 1; c < 40; c++) begin
      step();
      valid_in = 1'b0;
      #1;
      if (master_ready) begin
        cw = c;
        break;
      end
      if (master_valid && c > 1) begin
        abits = {abits[AW-2:0], wr_bus};
        na++;
      end
    end
    checks++;
    if (cw !== 18) begin errors++; $display("FAIL read_wait_entry: master_ready at cycle %0d expected 18", cw); end
    checks++;
    if (abits !== 16'h1234 || na !== 16) begin
      errors++; $display("FAIL read_addr: got %h (%0d bits) expected 1234 (16 bits)", abits, na);
    end
    checks++;
    if (mode !== 1'b0) begin errors++; $display("FAIL read_mode: got %b expected 0", mode); end
    for (int i = 0; i < 500; i++) begin
      step();
      slave_ready = 1'b0;
      split = 1'b1;
      #1;
      if (error) nerr++;
      if (!master_ready) mr_drop = 1'b1;
    end
    for (int i = 0; i < DW; i++) begin
      step();
      split = 1'b0;
      slave_valid = 1'b1;
      rd_bus = rpat[DW-1-i];
      #1;
      if (error) nerr++;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      slave_valid = 1'b0;
      rd_bus = 1'b0;
      #1;
      if (valid_out) begin
        got = 1'b1;
        rdat = uart_register_out;
        break;
      end
    end
    checks++;
    if (nerr !== 0 || mr_drop) begin
      errors++; $display("FAIL read_split_hold: error count %0d master_ready drop %0d expected 0 and 0", nerr, mr_drop);
    end
    checks++;
    if (!got || rdat !== 8'hE7) begin
      errors++; $display("FAIL read_data: valid_out %0d data %h expected 1 and e7", got, rdat);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [2:0] post;
    n = -1;
    step();
    valid_in = 1'b1;
    uart_register_in = {1'b1, 16'h0F0F, 8'h55};
    slave_ready = 1'b0;
    for (int c = 1; c < 400; c++) begin
      step();
      valid_in = 1'b0;
      #1;
      if (error) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycle: error at cycle %0d expected %0d", n, TIMEOUT + 1); end
    step();
    #1;
    post = {master_valid, ready_out, error};
    checks++;
    if (post !== 3'b010) begin errors++; $display("FAIL timeout_after: {mv,rdy,err} got %b expected 010", post); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] pat;
    logic [14:0] obs;
    logic [AW+DW-1:0] bits;
    int nvo, nbits, lat, nerr, nhold;
    bit mr_in;
    logic m;
    pat = 4'b1011; nvo = 0; mr_in = 0;
    step();
    valid_in = 1'b1;
    uart_register_in = {1'b0, 16'hBEEF, 8'h00};
    slave_ready = 1'b1;
    for (int c = 1; c < 40; c++) begin
      step();
      valid_in = 1'b0;
      #1;
      if (master_ready) break;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      slave_ready = 1'b0;
      slave_valid = 1'b1;
      rd_bus = pat[3-i];
    end
    step();
    slave_valid = 1'b0;
    rd_bus = 1'b0;
    rst = 1'b1;
    #1;
    mr_in = master_ready;
    step();
    rst = 1'b0;
    #1;
    obs = {ready_out, master_valid, master_ready, wr_bus, mode, valid_out, error, uart_register_out};
    checks++;
    if (!mr_in || obs !== {1'b1, 6'd0, 8'd0})
      $display("FAIL reset_mid_read: in-read %0d outputs %b expected 1 and %b", mr_in, obs, {1'b1, 6'd0, 8'd0});
    if (!mr_in || obs !== {1'b1, 6'd0, 8'd0}) errors++;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      if (valid_out || error) nvo++;
    end
    checks++;
    if (nvo !== 0) begin errors++; $display("FAIL reset_no_pulse: %0d pulses after reset expected 0", nvo); end
    run_frame({1'b1, 16'h5A5A, 8'hC3}, 1'b0, bits, nbits, lat, nerr, nhold, m);
    checks++;
    if (bits !== 24'h5A5AC3 || lat !== 26) begin
      errors++; $display("FAIL reset_recover: bits %h latency %0d expected 5a5ac3 and 26", bits, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*(AW+DW)-1:0] bits;
    int nb, vo1, vo2, acc2;
    bit prev_mv;
    bits = '0; nb = 0; vo1 = -1; vo2 = -1; acc2 = -1; prev_mv = 1'b0;
    step();
    valid_in = 1'b1;
    uart_register_in = {1'b1, 16'h1111, 8'h22};
    slave_ready = 1'b1;
    for (int c = 1; c < 100; c++) begin
      step();
      if (c == 1) uart_register_in = {1'b1, 16'h3333, 8'h44};
      if (acc2 >= 0) valid_in = 1'b0;
      #1;
      if (ready_out && valid_in && acc2 < 0) acc2 = c;
      if (master_valid && prev_mv) begin
        bits = {bits[2*(AW+DW)-2:0], wr_bus};
        nb++;
      end
      prev_mv = master_valid;
      if (valid_out) begin
        if (vo1 < 0) vo1 = c;
        else begin
          vo2 = c;
          break;
        end
      end
    end
    valid_in = 1'b0;
    slave_ready = 1'b0;
    checks++;
    if (vo1 !== 26) begin errors++; $display("FAIL b2b_first_done: cycle %0d expected 26", vo1); end
    checks++;
    if (acc2 !== 27) begin errors++; $display("FAIL b2b_second_accept: cycle %0d expected 27", acc2); end
    checks++;
    if (vo2 !== 53) begin errors++; $display("FAIL b2b_second_done: cycle %0d expected 53", vo2); end
    checks++;
    if (bits !== 48'h111122_333344 || nb !== 48) begin
      errors++; $display("FAIL b2b_bits: got %h (%0d bits) expected 111122333344 (48 bits)", bits, nb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_nostall();
    test_read_split();
    test_stall();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_bus_bridge.md
Name: master_bus_bridge

Overview:
Master-side end of the serial system bus; the counterpart of the slave bus bridge.
- Accepts one parallel request word {mode, addr, data} from the UART side.
- Serialises it MSB-first onto wr_bus under the master_valid / slave_ready handshake.
- For reads, deserialises the slave's rd_bus reply (slave_valid / master_ready) into a parallel word returned to the UART side.
- Sits between the UART receive/transmit logic and the bus arbiter/slave port.

Parameters:
ADDR_WIDTH, 16, address bits sent per transaction.
DATA_WIDTH, 8, data bits per write or read.
TIMEOUT, 255, max cycles waiting for slave_ready (REQ) or slave_valid (RD_WAIT) before abort; split stalls do not count.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
valid_in  in  1  request strobe from UART side.
uart_register_in  in  1+ADDR_WIDTH+DATA_WIDTH  request {mode, addr, wdata}; mode 1 = write, 0 = read.
ready_out  out  1  high only in IDLE; request is accepted when valid_in && ready_out.
uart_register_out  out  DATA_WIDTH  read data returned.
valid_out  out  1  one-cycle pulse: transaction complete (read data valid for reads).
error  out  1  one-cycle pulse: timeout abort.
mode  out  1  latched transaction mode, held stable for the whole transaction.
wr_bus  out  1  serial address/write data, MSB first.
master_valid  out  1  master driving a frame.
master_ready  out  1  master accepting read bits.
rd_bus  in  1  serial read data from slave.
slave_ready  in  1  slave sampling wr_bus this cycle.
slave_valid  in  1  slave driving rd_bus this cycle.
split  in  1  slave has split the transaction and will resume later.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; outputs ready_out=1, master_valid=0, master_ready=0, wr_bus=0, mode=0, valid_out=0, error=0, uart_register_out=0; all counters 0. Reset mid-transaction aborts at once with no valid_out and no error.
- Internal registers: shift_reg (ADDR_WIDTH+DATA_WIDTH), bit_cnt, tmo_cnt, rdata.
- IDLE:
  - On valid_in: latch mode, and load shift_reg = {addr, wdata}.
  - Go to REQ next cycle. valid_in outside IDLE is ignored.
- REQ:
  - master_valid=1; wr_bus = shift_reg MSB.
  - On slave_ready=1: go to ADDR_OUT.
  - Otherwise tmo_cnt increments; on tmo_cnt == TIMEOUT, pulse error and return to IDLE.
- ADDR_OUT, DATA_OUT:
  - master_valid=1; wr_bus = shift_reg MSB.
  - Each cycle with slave_ready=1: the bit is considered transferred, shift_reg shifts left, bit_cnt increments.
  - slave_ready=0 stalls: bit held, counter unchanged.
  - After ADDR_WIDTH bits: mode=1 goes to DATA_OUT; mode=0 drops master_valid and goes to RD_WAIT.
  - After DATA_WIDTH further bits: drop master_valid, go to DONE.
- RD_WAIT:
  - master_ready=1.
  - split=1 freezes tmo_cnt and remains in RD_WAIT.
  - On slave_valid=1: go to RD_IN, sampling the first bit in the same cycle.
  - Timeout (non-split cycles) gives error and returns to IDLE.
- RD_IN:
  - Each cycle with slave_valid && master_ready: rdata = {rdata[DATA_WIDTH-2:0], rd_bus}; bit_cnt increments.
  - After DATA_WIDTH bits: uart_register_out <= rdata, go to DONE.
- DONE: valid_out=1 for exactly one cycle, then IDLE.
- Latency, write at zero stall:
  - 1 (IDLE→REQ) + 1 (REQ) + ADDR_WIDTH + DATA_WIDTH + 1 (DONE) cycles from acceptance to valid_out.
  - Default 27 cycles.
- Counters:
  - bit_cnt is $clog2(ADDR_WIDTH+DATA_WIDTH+1) bits; cleared on each state entry.
  - No wrap is possible.
- Simultaneous valid_in and rst: rst wins.

Decomposition:
- Shared package bus_pkg holds:
  - state enum typedef for this block.
  - MODE_WRITE=1 / MODE_READ=0 constants.
  - Frame-field width helper localparams, shared with slave_bus_bridge.
- Sub-module: bus_shift_reg, a parametric PISO/SIPO with load/shift/enable.
  - Instantiate once for TX (shift_reg) and once for RX (rdata).

Test Plan:
- Write, no stall: uart_register_in={1,16'hA5C3,8'h3C}, slave_ready held 1 → wr_bus serialises 1010010111000011 then 00111100 MSB-first; valid_out pulses 27 cycles after accept; error=0.
- Read with split: request {0,16'h1234,8'h00}; after the address, hold split=1 for 500 cycles (above TIMEOUT), then slave_valid=1 driving 8'hE7 → no error, uart_register_out=8'hE7 with valid_out pulse.
- Handshake stalls: write {1,16'h0001,8'hFF}, toggle slave_ready every other cycle → wr_bus bit held during each stall; total bits transferred 24; data correct.
- Timeout: request with slave_ready never asserted → error pulse exactly TIMEOUT cycles after entering REQ; master_valid=0 and ready_out=1 the next cycle.
- Reset mid-read: assert rst during RD_IN after 4 bits → next cycle all outputs at reset values; no valid_out; next request completes normally.
- Back-to-back: valid_in held high across two requests → second accepted only on the cycle after DONE (ready_out=1); both complete in order.
